// File: rtl/rwc_irq_bank.sv
// rwc_irq_bank
//   Bank of NREG write-1-to-clear interrupt status registers. Each register k
//   has a companion mask register and a sticky overflow register at
//   BASE_ADDR+3k (status), +3k+1 (mask) and +3k+2 (overflow). Status bits are
//   set by rising edges on i_evt and cleared over the register bus: by
//   write-1-to-clear, or by read-to-clear when RC_MODE=1. A registered
//   per-register pending vector and a combined interrupt line are driven out.
//
//   Optional build macro RWC_IRQ_SYNC_EN: when defined, i_evt passes through a
//   two-flop synchroniser before edge detection (adds two cycles of latency).
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_wen, i_ren    bus write / read strobes
//   i_acc_en        access permission, gates both strobes
//   i_addr, i_wdata bus address / write data
//   o_rdata         combinational read data, 0 when no effective read
//   i_evt           level event inputs, register k at [k*DW +: DW]
//   o_status        current status bits, register k at [k*DW +: DW]
//   o_irq_vec       registered per-register pending (status & mask != 0)
//   o_irq           registered OR of all pending bits

module rwc_irq_bank #(
  parameter int            DW        = 8,
  parameter int            AW        = 8,
  parameter int            NREG      = 4,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter logic [DW-1:0] STS_RST   = '0,
  parameter logic [DW-1:0] MASK_RST  = '0,
  parameter logic          RC_MODE   = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wen,
  input  logic               i_ren,
  input  logic               i_acc_en,
  input  logic [AW-1:0]      i_addr,
  input  logic [DW-1:0]      i_wdata,
  output logic [DW-1:0]      o_rdata,
  input  logic [NREG*DW-1:0] i_evt,
  output logic [NREG*DW-1:0] o_status,
  output logic [NREG-1:0]    o_irq_vec,
  output logic               o_irq
);

  localparam longint LAST_ADDR = longint'(BASE_ADDR) + longint'(3 * NREG) - longint'(1);
  localparam longint MAX_ADDR  = (longint'(1) << AW) - longint'(1);

  generate
    if (NREG < 1 || NREG > 16) begin : g_bad_nreg
      $error("rwc_irq_bank: NREG must be in 1..16");
    end
    if (LAST_ADDR > MAX_ADDR) begin : g_bad_map
      $error("rwc_irq_bank: register map does not fit in the address space");
    end
  endgenerate

  logic [DW-1:0] sts_q [NREG];
  logic [DW-1:0] msk_q [NREG];
  logic [DW-1:0] ovf_q [NREG];

  logic [NREG*DW-1:0] evt_s;
  logic [NREG*DW-1:0] evt_d_q;
  logic [NREG*DW-1:0] evt_edge;

`ifdef RWC_IRQ_SYNC_EN
  logic [NREG*DW-1:0] sync1_q;
  logic [NREG*DW-1:0] sync2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_evt;
      sync2_q <= sync1_q;
    end
  end

  assign evt_s = sync2_q;
`else
  assign evt_s = i_evt;
`endif

  // evt_d resets to 0, so an input already high at reset release is seen as
  // a rising edge in the first clocked cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) evt_d_q <= '0;
    else          evt_d_q <= evt_s;
  end

  assign evt_edge = evt_s & ~evt_d_q;

  // Offset is one bit wider than the address so that addresses below
  // BASE_ADDR wrap to a large value and never match a register slot.
  logic [AW:0] off_ext;
  logic        wr_ok;
  logic        rd_ok;

  assign off_ext = {1'b0, i_addr} - {1'b0, BASE_ADDR};
  assign wr_ok   = i_wen & i_acc_en;
  assign rd_ok   = i_ren & i_acc_en;

  logic [NREG-1:0] wr_sts, wr_msk, wr_ovf, rd_sts;

  always_comb begin
    wr_sts  = '0;
    wr_msk  = '0;
    wr_ovf  = '0;
    rd_sts  = '0;
    o_rdata = '0;
    for (int k = 0; k < NREG; k++) begin
      if (off_ext == (AW+1)'(3 * k)) begin
        wr_sts[k] = wr_ok;
        rd_sts[k] = rd_ok;
        if (rd_ok) o_rdata = sts_q[k];
      end
      if (off_ext == (AW+1)'(3 * k + 1)) begin
        wr_msk[k] = wr_ok;
        if (rd_ok) o_rdata = msk_q[k];
      end
      if (off_ext == (AW+1)'(3 * k + 2)) begin
        wr_ovf[k] = wr_ok;
        if (rd_ok) o_rdata = ovf_q[k];
      end
    end
  end

  logic [DW-1:0]   sts_clr [NREG];
  logic [DW-1:0]   ovf_clr [NREG];
  logic [DW-1:0]   sts_d   [NREG];
  logic [DW-1:0]   ovf_d   [NREG];
  logic [NREG-1:0] pend;

  // A new edge always wins over a clear in the same cycle. Overflow looks at
  // the pre-update status, so it records the collision even when the bit is
  // being cleared at the same time.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      if (RC_MODE) sts_clr[k] = {DW{rd_sts[k]}} & sts_q[k];
      else         sts_clr[k] = {DW{wr_sts[k]}} & i_wdata;
      ovf_clr[k] = {DW{wr_ovf[k]}} & i_wdata;
      sts_d[k]   = evt_edge[k*DW +: DW] | (sts_q[k] & ~sts_clr[k]);
      ovf_d[k]   = (evt_edge[k*DW +: DW] & sts_q[k]) | (ovf_q[k] & ~ovf_clr[k]);
      pend[k]    = |(sts_q[k] & msk_q[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        sts_q[k] <= STS_RST;
        msk_q[k] <= MASK_RST;
        ovf_q[k] <= '0;
      end
      o_irq_vec <= '0;
      o_irq     <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        sts_q[k] <= sts_d[k];
        ovf_q[k] <= ovf_d[k];
        if (wr_msk[k]) msk_q[k] <= i_wdata;
      end
      o_irq_vec <= pend;
      o_irq     <= |pend;
    end
  end

  always_comb begin
    o_status = '0;
    for (int k = 0; k < NREG; k++) o_status[k*DW +: DW] = sts_q[k];
  end

endmodule

// File: tb/tb_rwc_irq_bank.sv
// Testbench for rwc_irq_bank: one write-1-to-clear instance and one
// read-to-clear instance share the bus and event inputs but have separate
// access enables. A behavioural model of the register bank is compared with
// both instances on every falling clock edge; directed sequences add literal
// expectations on top.

module tb_rwc_irq_bank;

  localparam logic [7:0] BASE = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen, ren, acc_w, acc_r;
  logic [7:0]  addr, wdata;
  logic [31:0] evt;
  logic [7:0]  rdata_w, rdata_r;
  logic [31:0] status_w, status_r;
  logic [3:0]  vec_w, vec_r;
  logic        irq_w, irq_r;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rwc_irq_bank #(.DW(8), .AW(8), .NREG(4), .BASE_ADDR(BASE), .RC_MODE(1'b0)) u_w1c (
    .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_ren(ren), .i_acc_en(acc_w),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata_w), .i_evt(evt),
    .o_status(status_w), .o_irq_vec(vec_w), .o_irq(irq_w));

  rwc_irq_bank #(.DW(8), .AW(8), .NREG(4), .BASE_ADDR(BASE), .RC_MODE(1'b1)) u_rc (
    .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_ren(ren), .i_acc_en(acc_r),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata_r), .i_evt(evt),
    .o_status(status_r), .o_irq_vec(vec_r), .o_irq(irq_r));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instance 0 clears status by write-1, instance 1 by read.
  logic [7:0]  m_sts [2][4];
  logic [7:0]  m_msk [2][4];
  logic [7:0]  m_ovf [2][4];
  logic [3:0]  m_vec [2];
  logic        m_irq [2];
  logic [31:0] m_prev;
  logic [3:0]  m_pend;
  logic [7:0]  m_e, m_old;
  logic        m_hit, m_wr, m_rd;
  int          m_off;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 4; k++) begin
          m_sts[i][k] = 8'h00;
          m_msk[i][k] = 8'h00;
          m_ovf[i][k] = 8'h00;
        end
        m_vec[i] = 4'h0;
        m_irq[i] = 1'b0;
      end
      m_prev = 32'h0;
    end else begin
      m_off = int'(addr) - int'(BASE);
      m_hit = (m_off >= 0) && (m_off < 12);
      for (int i = 0; i < 2; i++) begin
        m_wr = wen && ((i == 0) ? acc_w : acc_r) && m_hit;
        m_rd = ren && ((i == 0) ? acc_w : acc_r) && m_hit;
        for (int k = 0; k < 4; k++) begin
          m_e       = evt[k*8 +: 8] & ~m_prev[k*8 +: 8];
          m_old     = m_sts[i][k];
          m_pend[k] = |(m_old & m_msk[i][k]);
          if (i == 0 && m_wr && m_off / 3 == k && m_off % 3 == 0) m_sts[i][k] = m_old & ~wdata;
          if (i == 1 && m_rd && m_off / 3 == k && m_off % 3 == 0) m_sts[i][k] = 8'h00;
          m_sts[i][k] = m_sts[i][k] | m_e;
          if (m_wr && m_off / 3 == k && m_off % 3 == 2) m_ovf[i][k] = m_ovf[i][k] & ~wdata;
          m_ovf[i][k] = m_ovf[i][k] | (m_e & m_old);
          if (m_wr && m_off / 3 == k && m_off % 3 == 1) m_msk[i][k] = wdata;
        end
        m_vec[i] = m_pend;
        m_irq[i] = |m_pend;
      end
      m_prev = evt;
    end
  end

  function automatic logic [7:0] m_rdata(input int i);
    int off;
    off = int'(addr) - int'(BASE);
    if (!(ren && ((i == 0) ? acc_w : acc_r))) return 8'h00;
    if (off < 0 || off >= 12) return 8'h00;
    case (off % 3)
      0:       return m_sts[i][off/3];
      1:       return m_msk[i][off/3];
      default: return m_ovf[i][off/3];
    endcase
  endfunction

  always @(negedge clk) begin
    chk("w1c status", status_w, {m_sts[0][3], m_sts[0][2], m_sts[0][1], m_sts[0][0]});
    chk("w1c irq_vec", 32'(vec_w), 32'(m_vec[0]));
    chk("w1c irq", 32'(irq_w), 32'(m_irq[0]));
    chk("w1c rdata", 32'(rdata_w), 32'(m_rdata(0)));
    chk("rc status", status_r, {m_sts[1][3], m_sts[1][2], m_sts[1][1], m_sts[1][0]});
    chk("rc irq_vec", 32'(vec_r), 32'(m_vec[1]));
    chk("rc irq", 32'(irq_r), 32'(m_irq[1]));
    chk("rc rdata", 32'(rdata_r), 32'(m_rdata(1)));
  end

  // ---------------- bus helpers ----------------
  // All helpers start and end 1 ns after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d, input int tgt, input logic acc);
    addr = a; wdata = d; wen = 1'b1; ren = 1'b0;
    acc_w = (tgt == 0) && acc;
    acc_r = (tgt == 1) && acc;
    cyc();
    wen = 1'b0; acc_w = 1'b0; acc_r = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input int tgt, input logic acc, output logic [7:0] d);
    addr = a; ren = 1'b1; wen = 1'b0;
    acc_w = (tgt == 0) && acc;
    acc_r = (tgt == 1) && acc;
    #1;
    d = (tgt == 0) ? rdata_w : rdata_r;
    cyc();
    ren = 1'b0; acc_w = 1'b0; acc_r = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    rst_n = 1'b0;
    wen = 1'b0; ren = 1'b0; acc_w = 1'b0; acc_r = 1'b0;
    addr = 8'h00; wdata = 8'h00; evt = 32'h0;
    #23 rst_n = 1'b1;
    cyc();

    // reset state: every register of both instances reads 0
    for (int a = 0; a < 12; a++) begin
      bus_rd(BASE + 8'(a), 0, 1'b1, rd); chk("reset read w1c", 32'(rd), 32'h00);
      bus_rd(BASE + 8'(a), 1, 1'b1, rd); chk("reset read rc", 32'(rd), 32'h00);
    end
    chk("reset irq", 32'(irq_w | irq_r), 32'h0);

    // mask0 = 1, single-cycle event pulse on bit 0
    bus_wr(BASE + 8'd1, 8'h01, 0, 1'b1);
    evt[0] = 1'b1; cyc(); evt[0] = 1'b0;
    chk("status0 after pulse", 32'(status_w[7:0]), 32'h01);
    chk("irq one cycle after pulse", 32'(irq_w), 32'h0);
    cyc();
    chk("irq two cycles after pulse", 32'(irq_w), 32'h1);
    bus_rd(BASE, 0, 1'b1, rd); chk("read status0", 32'(rd), 32'h01);
    bus_wr(BASE, 8'h01, 0, 1'b1);
    chk("status0 after w1c", 32'(status_w[7:0]), 32'h00);
    chk("irq right after w1c", 32'(irq_w), 32'h1);
    cyc();
    chk("irq falls after w1c", 32'(irq_w), 32'h0);

    // held level sets once; a second edge records overflow
    evt[9] = 1'b1; repeat (10) cyc(); evt[9] = 1'b0;
    bus_rd(BASE + 8'd3, 0, 1'b1, rd); chk("status1 held", 32'(rd), 32'h02);
    bus_rd(BASE + 8'd5, 0, 1'b1, rd); chk("ovf1 held", 32'(rd), 32'h00);
    evt[9] = 1'b1; cyc(); evt[9] = 1'b0;
    bus_rd(BASE + 8'd5, 0, 1'b1, rd); chk("ovf1 second edge", 32'(rd), 32'h02);

    // W1C colliding with a new edge: set wins, overflow records it
    evt[0] = 1'b1; cyc(); evt[0] = 1'b0; cyc();
    evt[0] = 1'b1;
    bus_wr(BASE, 8'h01, 0, 1'b1);
    evt[0] = 1'b0;
    bus_rd(BASE, 0, 1'b1, rd);       chk("status0 set wins", 32'(rd), 32'h01);
    bus_rd(BASE + 8'd2, 0, 1'b1, rd); chk("ovf0 collision", 32'(rd), 32'h01);

    // read-to-clear instance
    evt[23] = 1'b1; cyc(); evt[23] = 1'b0;
    bus_rd(BASE + 8'd6, 1, 1'b1, rd); chk("rc status2 first read", 32'(rd), 32'h80);
    bus_rd(BASE + 8'd6, 1, 1'b1, rd); chk("rc status2 second read", 32'(rd), 32'h00);
    evt[23] = 1'b1; cyc(); evt[23] = 1'b0;
    bus_wr(BASE + 8'd6, 8'hFF, 1, 1'b1);
    bus_rd(BASE + 8'd6, 1, 1'b1, rd); chk("rc status2 write ignored", 32'(rd), 32'h80);

    // access permission and out-of-range addresses
    bus_wr(BASE + 8'd1, 8'hFF, 0, 1'b0);
    bus_rd(BASE, 0, 1'b0, rd);         chk("read without acc", 32'(rd), 32'h00);
    bus_rd(BASE + 8'd1, 0, 1'b1, rd);  chk("mask0 unchanged", 32'(rd), 32'h01);
    bus_rd(BASE, 0, 1'b1, rd);         chk("status0 still set", 32'(rd), 32'h01);
    bus_wr(BASE + 8'd12, 8'hFF, 0, 1'b1);
    bus_rd(BASE + 8'd12, 0, 1'b1, rd); chk("read past end", 32'(rd), 32'h00);
    bus_rd(BASE - 8'd1, 0, 1'b1, rd);  chk("read below base", 32'(rd), 32'h00);

    // randomized traffic, with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
      end
      evt   = evt ^ ($urandom & $urandom & $urandom);
      wen   = ($urandom_range(0, 2) == 0);
      ren   = ($urandom_range(0, 2) == 0);
      acc_w = ($urandom_range(0, 3) != 0);
      acc_r = ($urandom_range(0, 3) != 0);
      addr  = 8'($urandom_range(32'h0C, 32'h20));
      wdata = 8'($urandom);
      cyc();
    end
    wen = 1'b0; ren = 1'b0; acc_w = 1'b0; acc_r = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
